// File: rtl/ram_part_pkg.sv
// Shared types and helpers for the partitioned-RAM address driver.
package ram_part_pkg;

    typedef enum logic [2:0] {
        INIT,
        RUN,
        DRAIN,
        APPLY,
        SETTLE,
        WAIT_RDY
    } ramPartState_t;

    function automatic int settleCntWidth(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    // Partition number is the top partsLog bits of an index.
    function automatic int unsigned partitionOf(input int unsigned idx,
                                                input int unsigned indexW,
                                                input int unsigned partsLog);
        return (idx >> (indexW - partsLog)) & ((32'd1 << partsLog) - 32'd1);
    endfunction

endpackage

// File: rtl/onehot_word_decoder.sv
// Binary index to one-hot word line; all zeros when disabled.
module onehot_word_decoder #(
    parameter int INDEX = 6,
    parameter int DEPTH = 64
) (
    input  logic [INDEX-1:0] idx,
    input  logic             en,
    output logic [DEPTH-1:0] wordLine
);

    always_comb begin
        // NOTE: default first so every path assigns wordLine and no latch is inferred.
        wordLine = '0;
        if (en) wordLine[idx] = 1'b1;
    end

endmodule

// File: rtl/ram_partition_addr_driver.sv
// Driver for the decoder-less partitioned RAM: registered one-hot word lines plus power-gating FSM.
// Optional write-conflict filtering is enabled by defining RAM_PART_WR_CONFLICT_CHECK_EN.
module ram_partition_addr_driver
    import ram_part_pkg::*;
#(
    parameter int DEPTH         = 64,
    parameter int INDEX         = 6,
    parameter int NUM_RD_PORTS  = 4,
    parameter int NUM_WR_PORTS  = 2,
    parameter int NUM_PARTS     = 4,
    parameter int NUM_PARTS_LOG = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [NUM_RD_PORTS-1:0][INDEX-1:0]           rdIdx_i,
    input  logic [NUM_RD_PORTS-1:0]                      rdEn_i,
    input  logic [NUM_WR_PORTS-1:0][INDEX-1:0]           wrIdx_i,
    input  logic [NUM_WR_PORTS-1:0]                      wrEn_i,
    input  logic [NUM_PARTS_LOG:0]                       numPartsActive_i,
    input  logic                                         cfgReq_i,
    input  logic                                         ramReady_i,
    output logic [NUM_RD_PORTS-1:0][DEPTH-1:0]           rdAddr_o,
    output logic [NUM_RD_PORTS-1:0][NUM_PARTS_LOG-1:0]   rdDataPartition_o,
    output logic [NUM_WR_PORTS-1:0][DEPTH-1:0]           wrAddr_o,
    output logic [NUM_WR_PORTS-1:0]                      wrEn_o,
    output logic [NUM_PARTS-1:0]                         partitionGated_o,
    output logic                                         ready_o,
    output logic                                         cfgAck_o,
    output logic                                         cfgErr_o,
    output logic [NUM_RD_PORTS+NUM_WR_PORTS-1:0]         accessFault_o,
    output logic                                         wrConflict_o
);

    localparam int CNT_W    = NUM_PARTS_LOG + 1;
    localparam int SETTLE_W = settleCntWidth(SETTLE_CYCLES);

    ramPartState_t              state;
    logic [CNT_W-1:0]           activeCount;
    logic [SETTLE_W-1:0]        settleCnt;
    logic                       unGating;
    logic [NUM_PARTS-1:0]       applyMask;
    logic                       reqValid;

    logic [NUM_RD_PORTS-1:0][DEPTH-1:0]         rdLines;
    logic [NUM_RD_PORTS-1:0][NUM_PARTS_LOG-1:0] rdPart;
    logic [NUM_RD_PORTS-1:0]                    rdHit, rdFault;
    logic [NUM_WR_PORTS-1:0][DEPTH-1:0]         wrLines;
    logic [NUM_WR_PORTS-1:0][NUM_PARTS_LOG-1:0] wrPart;
    logic [NUM_WR_PORTS-1:0]                    wrReq, wrHit, wrFault;
    logic                                       wrConflictNext;

    assign reqValid = (numPartsActive_i != '0) && (numPartsActive_i <= CNT_W'(NUM_PARTS));

    always_comb begin
        for (int p = 0; p < NUM_PARTS; p++) applyMask[p] = (p >= int'(activeCount));
    end

`ifdef RAM_PART_WR_CONFLICT_CHECK_EN
    // A lower port loses to any higher enabled port writing the same index.
    always_comb begin
        wrReq          = wrEn_i;
        wrConflictNext = 1'b0;
        for (int w = 0; w < NUM_WR_PORTS; w++) begin
            for (int v = w + 1; v < NUM_WR_PORTS; v++) begin
                if (wrEn_i[w] && wrEn_i[v] && (wrIdx_i[w] == wrIdx_i[v])) begin
                    wrReq[w]       = 1'b0;
                    wrConflictNext = 1'b1;
                end
            end
        end
    end
`else
    assign wrReq          = wrEn_i;
    assign wrConflictNext = 1'b0;
`endif

    always_comb begin
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            rdPart[p]  = NUM_PARTS_LOG'(partitionOf(32'(rdIdx_i[p]), INDEX, NUM_PARTS_LOG));
            rdHit[p]   = rdEn_i[p] && ready_o && !partitionGated_o[rdPart[p]];
            rdFault[p] = rdEn_i[p] && ready_o &&  partitionGated_o[rdPart[p]];
        end
        for (int w = 0; w < NUM_WR_PORTS; w++) begin
            wrPart[w]  = NUM_PARTS_LOG'(partitionOf(32'(wrIdx_i[w]), INDEX, NUM_PARTS_LOG));
            wrHit[w]   = wrReq[w] && ready_o && !partitionGated_o[wrPart[w]];
            wrFault[w] = wrReq[w] && ready_o &&  partitionGated_o[wrPart[w]];
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : gRdDec
        onehot_word_decoder #(.INDEX(INDEX), .DEPTH(DEPTH)) uDec (
            .idx(rdIdx_i[p]), .en(rdHit[p]), .wordLine(rdLines[p])
        );
    end

    for (genvar w = 0; w < NUM_WR_PORTS; w++) begin : gWrDec
        onehot_word_decoder #(.INDEX(INDEX), .DEPTH(DEPTH)) uDec (
            .idx(wrIdx_i[w]), .en(wrHit[w]), .wordLine(wrLines[w])
        );
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            rdAddr_o          <= '0;
            rdDataPartition_o <= '0;
            wrAddr_o          <= '0;
            wrEn_o            <= '0;
            accessFault_o     <= '0;
            wrConflict_o      <= 1'b0;
        end else begin
            rdAddr_o <= rdLines;
            for (int p = 0; p < NUM_RD_PORTS; p++)
                rdDataPartition_o[p] <= rdHit[p] ? rdPart[p] : '0;
            wrAddr_o      <= wrLines;
            wrEn_o        <= wrHit;
            accessFault_o <= {wrFault, rdFault};
            wrConflict_o  <= wrConflictNext && ready_o;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= INIT;
            ready_o          <= 1'b0;
            cfgAck_o         <= 1'b0;
            cfgErr_o         <= 1'b0;
            partitionGated_o <= '0;
            activeCount      <= CNT_W'(NUM_PARTS);
            settleCnt        <= '0;
            unGating         <= 1'b0;
        end else begin
            cfgAck_o <= 1'b0;
            cfgErr_o <= 1'b0;
            case (state)
                INIT: if (ramReady_i) begin
                    state   <= RUN;
                    ready_o <= 1'b1;
                end
                RUN: if (cfgReq_i) begin
                    if (reqValid) begin
                        activeCount <= numPartsActive_i;
                        state       <= DRAIN;
                        ready_o     <= 1'b0;
                    end else begin
                        cfgErr_o <= 1'b1;
                    end
                end
                DRAIN: begin
                    partitionGated_o <= applyMask;
                    unGating         <= |(partitionGated_o & ~applyMask);
                    state            <= APPLY;
                end
                APPLY: begin
                    settleCnt <= SETTLE_W'(SETTLE_CYCLES - 1);
                    state     <= unGating ? SETTLE : WAIT_RDY;
                end
                SETTLE: begin
                    if (settleCnt == '0) state <= WAIT_RDY;
                    else                 settleCnt <= settleCnt - 1'b1;
                end
                WAIT_RDY: if (ramReady_i) begin
                    state    <= RUN;
                    ready_o  <= 1'b1;
                    cfgAck_o <= 1'b1;
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule
